ship_placement: RTL and testbench

- Ship-placement controller for the battleship lab. Sits directly downstream of the ship-count decision stage.
- Once ships_decided is seen, it latches the requested ship count. The player then moves a cursor over a ROWS x COLS board and drops single-cell ships.
- It rejects placements on occupied cells and asserts placement_done when all ships are on the board.
- The board bitmap feeds the display and the later attack stage.

---
 rtl/battleship_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 36 +++
 rtl/ship_placement.sv | 144 ++++++++++++++
 tb/tb_ship_placement.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship lab blocks.
// Grid defaults and board cell indexing live here.
package battleship_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLACING = 2'd1,
    DONE    = 2'd2
  } placement_state_t;

  localparam int GRID_ROWS = 5;
  localparam int GRID_COLS = 5;
  localparam int MAX_SHIPS = 5;

  function automatic int unsigned cell_index(
    input int unsigned x,
    input int unsigned y,
    input int unsigned cols = GRID_COLS
  );
    return y * cols + x;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up/down counter with wrap at both ends.
// Simultaneous inc and dec cancel; clr wins over both.
module wrap_counter #(
  parameter  int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !dec) begin
      q_d = (q_q == W'(N - 1)) ? '0 : q_q + W'(1);
    end else if (dec && !inc) begin
      q_d = (q_q == '0) ? W'(N - 1) : q_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ship_placement.sv
// Cursor-driven single-cell ship placement over the game board.
// All outputs come straight from flops.
module ship_placement #(
  parameter int ROWS      = battleship_pkg::GRID_ROWS,
  parameter int COLS      = battleship_pkg::GRID_COLS,
  parameter int MAX_SHIPS = battleship_pkg::MAX_SHIPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ships_decided,
  input  logic [2:0]               player_amount_ships,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_place,
  input  logic                     clear_board,
  output logic [$clog2(COLS)-1:0]  cursor_x,
  output logic [$clog2(ROWS)-1:0]  cursor_y,
  output logic [ROWS*COLS-1:0]     board,
  output logic [2:0]               ships_placed,
  output logic                     place_error,
  output logic                     busy,
  output logic                     placement_done
);
  import battleship_pkg::*;

  localparam int NC = ROWS * COLS;

  placement_state_t state_d, state_q;
  logic [NC-1:0] board_d, board_q;
  logic [2:0]    ships_placed_d, ships_placed_q;
  logic [2:0]    target_d, target_q;
  logic          place_error_d, place_error_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  logic          clr_cur;
  logic          one_move;
  logic          move_ok;
  logic [NC-1:0] cell_mask;
  logic          count_ok;

  assign count_ok = (player_amount_ships != 3'd0) &&
                    (32'(player_amount_ships) <= MAX_SHIPS);

  assign one_move = ($countones({btn_up, btn_down,
                                 btn_left, btn_right}) == 1);

  assign move_ok = (state_q == PLACING) && !clear_board &&
                   !btn_place && one_move;

  assign cell_mask = {{(NC-1){1'b0}}, 1'b1} <<
    cell_index(32'(cursor_x), 32'(cursor_y), COLS);

  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    ships_placed_d = ships_placed_q;
    target_d       = target_q;
    place_error_d  = 1'b0;
    clr_cur        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ships_decided && count_ok) begin
          target_d = player_amount_ships;
          state_d  = PLACING;
        end
      end
      PLACING: begin
        if (clear_board) begin
          state_d        = IDLE;
          board_d        = '0;
          ships_placed_d = '0;
          clr_cur        = 1'b1;
        end else if (btn_place) begin
          if (|(board_q & cell_mask)) begin
            place_error_d = 1'b1;
          end else begin
            board_d        = board_q | cell_mask;
            ships_placed_d = ships_placed_q + 3'd1;
            if (ships_placed_d == target_q) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (clear_board) begin
          state_d        = IDLE;
          board_d        = '0;
          ships_placed_d = '0;
          clr_cur        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PLACING);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      board_q        <= '0;
      ships_placed_q <= '0;
      target_q       <= '0;
      place_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      ships_placed_q <= ships_placed_d;
      target_q       <= target_d;
      place_error_q  <= place_error_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  wrap_counter #(.N(COLS)) u_x (
    .clk (clk),
    .rst (rst),
    .clr (clr_cur),
    .inc (move_ok && btn_right),
    .dec (move_ok && btn_left),
    .q   (cursor_x)
  );

  wrap_counter #(.N(ROWS)) u_y (
    .clk (clk),
    .rst (rst),
    .clr (clr_cur),
    .inc (move_ok && btn_down),
    .dec (move_ok && btn_up),
    .q   (cursor_y)
  );

  assign board          = board_q;
  assign ships_placed   = ships_placed_q;
  assign place_error    = place_error_q;
  assign busy           = busy_q;
  assign placement_done = done_q;

endmodule

// File: tb/tb_ship_placement.sv
// Bench for ship_placement: directed plan plus random cycles
// against a grid-level reference model.
module tb_ship_placement;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int MAXS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       ships_decided = 1'b0;
  logic [2:0] player_amount_ships = 3'd0;
  logic       btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_place = 1'b0, clear_board = 1'b0;
  logic [$clog2(COLS)-1:0] cursor_x;
  logic [$clog2(ROWS)-1:0] cursor_y;
  logic [ROWS*COLS-1:0]    board;
  logic [2:0]              ships_placed;
  logic place_error, busy, placement_done;

  ship_placement #(.ROWS(ROWS), .COLS(COLS), .MAX_SHIPS(MAXS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ships_decided       (ships_decided),
    .player_amount_ships (player_amount_ships),
    .btn_up              (btn_up),
    .btn_down            (btn_down),
    .btn_left            (btn_left),
    .btn_right           (btn_right),
    .btn_place           (btn_place),
    .clear_board         (clear_board),
    .cursor_x            (cursor_x),
    .cursor_y            (cursor_y),
    .board               (board),
    .ships_placed        (ships_placed),
    .place_error         (place_error),
    .busy                (busy),
    .placement_done      (placement_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: occupancy grid, cursor, counts and a phase name.
  bit occ [ROWS][COLS];
  int mx, my, mplaced, mtarget;
  int mphase;  // 0 idle, 1 placing, 2 done
  bit merr;

  function automatic logic [31:0] model_board();
    logic [31:0] b = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (occ[y][x]) b[y*COLS + x] = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        occ[y][x] = 1'b0;
    mx = 0;
    my = 0;
    mplaced = 0;
  endtask

  task automatic model_update(input bit r, sd, input int cnt,
                              input bit u, dn, l, rt, p, c);
    int nmoves;
    merr = 1'b0;
    if (!r) begin
      model_clear();
      mtarget = 0;
      mphase = 0;
      return;
    end
    nmoves = int'(u) + int'(dn) + int'(l) + int'(rt);
    if (mphase == 0) begin
      if (sd && cnt >= 1 && cnt <= MAXS) begin
        mtarget = cnt;
        mphase = 1;
      end
    end else if (mphase == 1) begin
      if (c) begin
        model_clear();
        mphase = 0;
      end else if (p) begin
        if (occ[my][mx]) merr = 1'b1;
        else begin
          occ[my][mx] = 1'b1;
          mplaced++;
          if (mplaced == mtarget) mphase = 2;
        end
      end else if (nmoves == 1) begin
        if (u)  my = (my + ROWS - 1) % ROWS;
        if (dn) my = (my + 1) % ROWS;
        if (l)  mx = (mx + COLS - 1) % COLS;
        if (rt) mx = (mx + 1) % COLS;
      end
    end else begin
      if (c) begin
        model_clear();
        mphase = 0;
      end
    end
  endtask

  task automatic step(input bit r = 1, input bit sd = 0,
                      input int cnt = 0,
                      input bit u = 0, input bit dn = 0,
                      input bit l = 0, input bit rt = 0,
                      input bit p = 0, input bit c = 0);
    @(negedge clk);
    rst = r;
    ships_decided = sd;
    player_amount_ships = 3'(cnt);
    btn_up = u;
    btn_down = dn;
    btn_left = l;
    btn_right = rt;
    btn_place = p;
    clear_board = c;
    @(posedge clk);
    model_update(r, sd, cnt, u, dn, l, rt, p, c);
    #1;
    check("cursor_x", 32'(cursor_x), 32'(mx));
    check("cursor_y", 32'(cursor_y), 32'(my));
    check("board", 32'(board), model_board());
    check("ships_placed", 32'(ships_placed), 32'(mplaced));
    check("place_error", 32'(place_error), 32'(merr));
    check("busy", 32'(busy), 32'(mphase == 1));
    check("done", 32'(placement_done), 32'(mphase == 2));
  endtask

  initial begin
    model_clear();
    mtarget = 0;
    mphase = 0;
    merr = 0;

    step(.r(0));
    check("rst_board", 32'(board), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step(.sd(1), .cnt(0));
    step(.sd(1), .cnt(6));
    check("bad_cnt_idle", 32'(busy), 32'h0);
    step(.sd(1), .cnt(3));
    check("cnt3_busy", 32'(busy), 32'h1);

    step(.r(0));
    step(.sd(1), .cnt(2));
    step(.l(1));
    check("left_wrap", 32'(cursor_x), 32'd4);
    step(.u(1));
    check("up_wrap", 32'(cursor_y), 32'd4);
    step(.rt(1));
    check("right_wrap", 32'(cursor_x), 32'd0);
    step(.dn(1));
    check("down_wrap", 32'(cursor_y), 32'd0);
    step(.p(1));
    check("place0", 32'(board), 32'h1);
    step(.p(1));
    check("dup_err", 32'(place_error), 32'h1);
    check("dup_cnt", 32'(ships_placed), 32'd1);
    step();
    check("err_pulse", 32'(place_error), 32'h0);
    step(.u(1), .l(1));
    check("multi_x", 32'(cursor_x), 32'd0);
    step(.rt(1));
    step(.p(1));
    check("final_board", 32'(board), 32'h3);
    check("final_done", 32'(placement_done), 32'h1);
    step(.l(1));
    step(.p(1));
    check("done_hold", 32'(board), 32'h3);
    step(.c(1));
    check("clr_board", 32'(board), 32'h0);

    step(.sd(1), .cnt(3));
    step(.p(1), .rt(1));
    check("pp_x", 32'(cursor_x), 32'd0);
    check("pp_board", 32'(board), 32'h1);
    step(.dn(1));
    step(.p(1));
    check("two_placed", 32'(ships_placed), 32'd2);
    step(.r(0));
    check("mid_rst", 32'(ships_placed), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      automatic bit r  = ($urandom_range(199) != 0);
      automatic bit sd = ($urandom_range(3) == 0);
      automatic int cn = int'($urandom_range(7));
      automatic bit u  = ($urandom_range(4) == 0);
      automatic bit dn = ($urandom_range(4) == 0);
      automatic bit l  = ($urandom_range(4) == 0);
      automatic bit rt = ($urandom_range(4) == 0);
      automatic bit p  = ($urandom_range(3) == 0);
      automatic bit c  = ($urandom_range(39) == 0);
      step(r, sd, cn, u, dn, l, rt, p, c);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
